red_centroid_tracker: RTL and testbench

//  Consumes de-Bayered RGB pixels from the RAW-to-RGB stage on VGA_CLK, classifies

---
 rtl/red_centroid_tracker_if.sv | 32 +++
 rtl/red_centroid_tracker.sv | 226 ++++++++++++++++++++++
 tb/tb_red_centroid_tracker.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/red_centroid_tracker_if.sv
`timescale 1ns/1ps
// Pixel stream in, centroid results out, for red_centroid_tracker.
// The master side drives pixels and sync; the slave side (the tracker) drives results.
interface red_centroid_tracker_if #(
  parameter int unsigned CntW = 20
);
  logic [11:0]     red;
  logic [11:0]     green;
  logic [11:0]     blue;
  logic            dval;
  logic [10:0]     x;
  logic [10:0]     y;
  logic            vga_vs;

  logic            mask;
  logic [10:0]     x_center;
  logic [10:0]     y_center;
  logic [CntW-1:0] pix_count;
  logic            locked;
  logic            valid;
  logic [43:0]     box;

  modport master (
    output red, green, blue, dval, x, y, vga_vs,
    input  mask, x_center, y_center, pix_count, locked, valid, box
  );

  modport slave (
    input  red, green, blue, dval, x, y, vga_vs,
    output mask, x_center, y_center, pix_count, locked, valid, box
  );
endinterface

// File: rtl/red_centroid_tracker.sv
`timescale 1ns/1ps
// Red-target classifier with per-frame centroid computed by a serial restoring divider.
// Define RED_TRACK_BBOX_EN to also track the red-pixel bounding box on the box output.
module red_centroid_tracker #(
  parameter logic [11:0] Thresh = 12'd256,
  parameter int unsigned MinPix = 64,
  parameter int unsigned CntW   = 20
) (
  input logic                  vga_clk,
  input logic                  rst_n,
  red_centroid_tracker_if.slave bus
);

  localparam int unsigned       QuoW     = CntW + 11;
  localparam int unsigned       StepW    = $clog2(QuoW);
  localparam logic [CntW-1:0]   CntMax   = '1;
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [CntW-1:0]   MinPixW  = CntW'(MinPix);
  localparam logic [StepW-1:0]  StepLast = StepW'(QuoW - 1);
  localparam logic [StepW-1:0]  StepOne  = StepW'(1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e            state_q;
  logic              vs_q;
  logic              mask_q;
  logic              sat_q;
  logic [CntW-1:0]   cnt_q;
  logic [QuoW-1:0]   sx_q;
  logic [QuoW-1:0]   sy_q;

  logic              pend_q;
  logic              sat_snap_q;
  logic [CntW-1:0]   dvs_q;
  logic [QuoW-1:0]   dvd_x_q;
  logic [QuoW-1:0]   dvd_y_q;
  logic [CntW-1:0]   rem_x_q;
  logic [CntW-1:0]   rem_y_q;
  logic [StepW-1:0]  step_q;

  logic [10:0]       x_center_q;
  logic [10:0]       y_center_q;
  logic [CntW-1:0]   pix_count_q;
  logic              locked_q;
  logic              valid_q;

  // Classification, 13-bit compares so G/B + Thresh cannot wrap.
  logic [12:0] r_ext;
  logic [12:0] g_lim;
  logic [12:0] b_lim;
  logic        red_hit;
  logic        frame_end;

  always_comb begin
    r_ext     = {1'b0, bus.red};
    g_lim     = {1'b0, bus.green} + {1'b0, Thresh};
    b_lim     = {1'b0, bus.blue} + {1'b0, Thresh};
    red_hit   = bus.dval & (r_ext > g_lim) & (r_ext > b_lim);
    frame_end = ~bus.vga_vs & vs_q;
  end

  // Per-frame accumulators; a red pixel on the frame-end cycle is dropped.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b1;
      mask_q <= 1'b0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
    end else begin
      vs_q   <= bus.vga_vs;
      mask_q <= red_hit;
      if (frame_end) begin
        sat_q <= 1'b0;
        cnt_q <= '0;
        sx_q  <= '0;
        sy_q  <= '0;
      end else if (red_hit) begin
        if (cnt_q == CntMax) begin
          sat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CntOne;
          sx_q  <= sx_q + QuoW'(bus.x);
          sy_q  <= sy_q + QuoW'(bus.y);
        end
      end
    end
  end

  // One restoring step per cycle for both axes; divisor is never below MinPix here.
  logic [CntW:0]   trial_x;
  logic [CntW:0]   trial_y;
  logic            ge_x;
  logic            ge_y;
  logic [CntW-1:0] rem_x_nxt;
  logic [CntW-1:0] rem_y_nxt;

  always_comb begin
    trial_x   = {rem_x_q, dvd_x_q[QuoW-1]};
    trial_y   = {rem_y_q, dvd_y_q[QuoW-1]};
    ge_x      = trial_x >= {1'b0, dvs_q};
    ge_y      = trial_y >= {1'b0, dvs_q};
    rem_x_nxt = ge_x ? trial_x[CntW-1:0] - dvs_q : trial_x[CntW-1:0];
    rem_y_nxt = ge_y ? trial_y[CntW-1:0] - dvs_q : trial_y[CntW-1:0];
  end

  // Snapshot is taken only when idle; the lock decision happens one cycle later.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      sat_snap_q  <= 1'b0;
      dvs_q       <= '0;
      dvd_x_q     <= '0;
      dvd_y_q     <= '0;
      rem_x_q     <= '0;
      rem_y_q     <= '0;
      step_q      <= '0;
      x_center_q  <= '0;
      y_center_q  <= '0;
      pix_count_q <= '0;
      locked_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_end) begin
            dvd_x_q    <= sx_q;
            dvd_y_q    <= sy_q;
            dvs_q      <= cnt_q;
            sat_snap_q <= sat_q;
            pend_q     <= 1'b1;
          end else if (pend_q) begin
            if (dvs_q >= MinPixW && !sat_snap_q) begin
              state_q <= StDiv;
              rem_x_q <= '0;
              rem_y_q <= '0;
              step_q  <= '0;
            end else begin
              pix_count_q <= dvs_q;
              locked_q    <= 1'b0;
              valid_q     <= 1'b1;
            end
          end
        end
        StDiv: begin
          dvd_x_q <= {dvd_x_q[QuoW-2:0], ge_x};
          dvd_y_q <= {dvd_y_q[QuoW-2:0], ge_y};
          rem_x_q <= rem_x_nxt;
          rem_y_q <= rem_y_nxt;
          step_q  <= step_q + StepOne;
          if (step_q == StepLast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          x_center_q  <= dvd_x_q[10:0];
          y_center_q  <= dvd_y_q[10:0];
          pix_count_q <= dvs_q;
          locked_q    <= 1'b1;
          valid_q     <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RED_TRACK_BBOX_EN
  logic [10:0] xmin_q;
  logic [10:0] xmax_q;
  logic [10:0] ymin_q;
  logic [10:0] ymax_q;
  logic [43:0] box_snap_q;
  logic [43:0] box_q;

  // Min trackers rest at 2047 so the first red pixel of a frame always wins.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_q <= 11'h7ff;
      xmax_q <= '0;
      ymin_q <= 11'h7ff;
      ymax_q <= '0;
    end else if (frame_end) begin
      xmin_q <= 11'h7ff;
      xmax_q <= '0;
      ymin_q <= 11'h7ff;
      ymax_q <= '0;
    end else if (red_hit) begin
      if (bus.x < xmin_q) xmin_q <= bus.x;
      if (bus.x > xmax_q) xmax_q <= bus.x;
      if (bus.y < ymin_q) ymin_q <= bus.y;
      if (bus.y > ymax_q) ymax_q <= bus.y;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      box_snap_q <= '0;
      box_q      <= '0;
    end else begin
      if (frame_end && state_q == StIdle) begin
        box_snap_q <= {xmin_q, xmax_q, ymin_q, ymax_q};
      end
      if (state_q == StDone) begin
        box_q <= box_snap_q;
      end
    end
  end

  assign bus.box = box_q;
`else
  assign bus.box = 44'd0;
`endif

  assign bus.mask      = mask_q;
  assign bus.x_center  = x_center_q;
  assign bus.y_center  = y_center_q;
  assign bus.pix_count = pix_count_q;
  assign bus.locked    = locked_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_red_centroid_tracker.sv
`timescale 1ns/1ps
// Randomised bench for red_centroid_tracker against a frame-level arithmetic model.
// Honours RED_TRACK_BBOX_EN the same way the design does.
module tb_red_centroid_tracker;
  localparam int unsigned CntW = 20;

  logic clk;
  logic rst_n;

  red_centroid_tracker_if #(.CntW(CntW)) bus ();

  red_centroid_tracker #(
    .Thresh (12'd256),
    .MinPix (64),
    .CntW   (CntW)
  ) dut (
    .vga_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.valid === 1'b1) vcount++;

  // Frame model: plain sums over the pixels judged red.
  int          m_cnt;
  longint      m_sx, m_sy;
  int          m_xmin, m_xmax, m_ymin, m_ymax;
  int          e_x, e_y, e_pix, e_lat;
  logic        e_locked;
  logic [43:0] e_box;
  logic        last_red;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 2047; m_xmax = 0; m_ymin = 2047; m_ymax = 0;
  endtask

  task automatic model_reset();
    model_clear();
    e_x = 0; e_y = 0; e_pix = 0; e_locked = 1'b0; e_box = '0;
  endtask

  task automatic model_close();
    e_pix = m_cnt;
    if (m_cnt >= 64) begin
      e_locked = 1'b1;
      e_x      = int'(m_sx / m_cnt) % 2048;
      e_y      = int'(m_sy / m_cnt) % 2048;
      e_lat    = CntW + 13;
`ifdef RED_TRACK_BBOX_EN
      e_box = {11'(m_xmin), 11'(m_xmax), 11'(m_ymin), 11'(m_ymax)};
`endif
    end else begin
      e_locked = 1'b0;
      e_lat    = 1;
    end
    model_clear();
  endtask

  task automatic drive_px(input int r, input int g, input int b, input bit dv,
                          input int x, input int y);
    bus.red = 12'(r); bus.green = 12'(g); bus.blue = 12'(b);
    bus.dval = dv; bus.x = 11'(x); bus.y = 11'(y);
    last_red = dv && (r > g + 256) && (r > b + 256);
    if (last_red) begin
      m_cnt++; m_sx += x; m_sy += y;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
    tick();
  endtask

  // Pulse VS low for one sample, then count cycles from the detecting edge to valid.
  task automatic close_frame(output int lat, output bit seen);
    bus.dval = 1'b0; bus.vga_vs = 1'b0;
    tick();
    bus.vga_vs = 1'b1;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (bus.valid === 1'b1) begin
        seen = 1'b1; lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      bus.red = 12'd4000; bus.green = 12'd100; bus.blue = 12'd100; bus.dval = 1'b1;
      bus.x = 11'(i); bus.y = 11'(i); bus.vga_vs = (i % 3 != 0);
      tick();
      checks++;
      if ({bus.mask, bus.x_center, bus.y_center, bus.pix_count, bus.locked, bus.valid,
           bus.box} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got mask=%b x=%0d y=%0d pix=%0d lk=%b v=%b want all 0",
                 bus.mask, bus.x_center, bus.y_center, bus.pix_count, bus.locked, bus.valid);
      end
    end
    bus.vga_vs = 1'b1; bus.dval = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL reset_valid: got %0d pulses want 0", vcount);
    end
  endtask

  task automatic test_block();
    int lat; bit seen;
    for (int y = 50; y <= 65; y++)
      for (int x = 100; x <= 115; x++) begin
        drive_px(4000, 100, 100, 1'b1, x, y);
        checks++;
        if (bus.mask !== 1'b1) begin
          errors++;
          $display("FAIL block_mask: got %b want 1 at (%0d,%0d)", bus.mask, x, y);
        end
      end
    close_frame(lat, seen);
    model_close();
    checks++;
    if (!seen || lat != e_lat) begin
      errors++;
      $display("FAIL block_latency: got seen=%b lat=%0d want lat=%0d", seen, lat, e_lat);
    end
    checks++;
    if (bus.pix_count !== 256 || bus.x_center !== 11'd107 || bus.y_center !== 11'd57 ||
        bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL block_result: got pix=%0d x=%0d y=%0d lk=%b want 256 107 57 1",
               bus.pix_count, bus.x_center, bus.y_center, bus.locked);
    end
    checks++;
`ifdef RED_TRACK_BBOX_EN
    if (bus.box !== {11'd100, 11'd115, 11'd50, 11'd65}) begin
`else
    if (bus.box !== 44'd0) begin
`endif
      errors++;
      $display("FAIL block_box: got %h want %h", bus.box, e_box);
    end
  endtask

  task automatic test_threshold();
    int lat; bit seen;
    int r[5] = '{1256, 1257, 4000, 1257, 1256};
    int g[5] = '{1000, 1000, 0, 0, 0};
    int b[5] = '{0, 0, 0, 1000, 1000};
    bit d[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic w[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_px(r[i], g[i], b[i], d[i], 10 + i, 20 + i);
      checks++;
      if (bus.mask !== w[i]) begin
        errors++;
        $display("FAIL thresh_mask%0d: got %b want %b", i, bus.mask, w[i]);
      end
    end
    close_frame(lat, seen);
    model_close();
    checks++;
    if (!seen || lat != e_lat) begin
      errors++;
      $display("FAIL thresh_latency: got seen=%b lat=%0d want %0d", seen, lat, e_lat);
    end
    checks++;
    if ({bus.pix_count, bus.locked, bus.x_center, bus.y_center, bus.box} !==
        {CntW'(e_pix), e_locked, 11'(e_x), 11'(e_y), e_box}) begin
      errors++;
      $display("FAIL thresh_result: got pix=%0d lk=%b x=%0d y=%0d want %0d %b %0d %0d",
               bus.pix_count, bus.locked, bus.x_center, bus.y_center, e_pix, e_locked, e_x, e_y);
    end
  endtask

  task automatic test_below_min();
    int lat; bit seen;
    for (int i = 0; i < 63; i++)
      drive_px(3000, $urandom_range(2000), $urandom_range(2000), 1'b1,
               $urandom_range(2047), $urandom_range(2047));
    close_frame(lat, seen);
    model_close();
    checks++;
    if (!seen || lat != 1) begin
      errors++;
      $display("FAIL below_latency: got seen=%b lat=%0d want 1", seen, lat);
    end
    checks++;
    if (bus.pix_count !== 63 || bus.locked !== 1'b0 || bus.x_center !== 11'd107 ||
        bus.y_center !== 11'd57 || bus.box !== e_box) begin
      errors++;
      $display("FAIL below_result: got pix=%0d lk=%b x=%0d y=%0d want 63 0 107 57",
               bus.pix_count, bus.locked, bus.x_center, bus.y_center);
    end
  endtask

  task automatic test_vs_during_div();
    int lat, v0; bit seen;
    for (int i = 0; i < 100; i++)
      drive_px(3500, $urandom_range(3000), $urandom_range(3000), 1'b1,
               $urandom_range(2047), $urandom_range(2047));
    v0 = vcount;
    bus.dval = 1'b0; bus.vga_vs = 1'b0;
    tick();
    bus.vga_vs = 1'b1;
    model_close();
    for (int i = 0; i < 5; i++) drive_px(4000, 0, 0, 1'b1, 7, 9);
    bus.dval = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.vga_vs = 1'b0;
    tick();
    bus.vga_vs = 1'b1;
    model_clear();  // frame ended while busy: its pixels are thrown away
    seen = 1'b0; lat = 0;
    for (int n = 12; n <= 100; n++) begin
      tick();
      if (bus.valid === 1'b1) begin
        seen = 1'b1; lat = n;
        break;
      end
    end
    checks++;
    if (!seen || lat != e_lat) begin
      errors++;
      $display("FAIL overlap_latency: got seen=%b lat=%0d want %0d", seen, lat, e_lat);
    end
    checks++;
    if ({bus.pix_count, bus.locked, bus.x_center, bus.y_center, bus.box} !==
        {CntW'(e_pix), e_locked, 11'(e_x), 11'(e_y), e_box}) begin
      errors++;
      $display("FAIL overlap_result: got pix=%0d lk=%b x=%0d y=%0d want %0d %b %0d %0d",
               bus.pix_count, bus.locked, bus.x_center, bus.y_center, e_pix, e_locked, e_x, e_y);
    end
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (vcount !== v0 + 1) begin
      errors++;
      $display("FAIL overlap_pulses: got %0d want %0d", vcount - v0, 1);
    end
    for (int i = 0; i < 70; i++)
      drive_px(2500, $urandom_range(2000), $urandom_range(2000), 1'b1,
               $urandom_range(2047), $urandom_range(2047));
    close_frame(lat, seen);
    model_close();
    checks++;
    if (!seen || lat != e_lat || bus.pix_count !== 70 || bus.x_center !== 11'(e_x) ||
        bus.y_center !== 11'(e_y) || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL overlap_next: got lat=%0d pix=%0d x=%0d y=%0d want %0d 70 %0d %0d",
               lat, bus.pix_count, bus.x_center, bus.y_center, e_lat, e_x, e_y);
    end
  endtask

  task automatic test_random();
    int lat, npx, r, g, b; bit seen, dv;
    for (int f = 0; f < 8; f++) begin
      npx = $urandom_range(130, 30);
      for (int i = 0; i < npx; i++) begin
        dv = ($urandom_range(9) != 0);
        case ($urandom_range(3))
          0, 1: begin
            r = $urandom_range(4095, 1500);
            g = $urandom_range(r - 257);
            b = $urandom_range(r - 257);
          end
          2: begin
            r = $urandom_range(4095, 600);
            g = r - 256 - $urandom_range(1);
            b = $urandom_range(100);
          end
          default: begin
            r = $urandom_range(4095); g = $urandom_range(4095); b = $urandom_range(4095);
          end
        endcase
        drive_px(r, g, b, dv, $urandom_range(2047), $urandom_range(2047));
        checks++;
        if (bus.mask !== last_red) begin
          errors++;
          $display("FAIL rand_mask: got %b want %b (r=%0d g=%0d b=%0d dv=%b)",
                   bus.mask, last_red, r, g, b, dv);
        end
      end
      close_frame(lat, seen);
      model_close();
      checks++;
      if (!seen || lat != e_lat) begin
        errors++;
        $display("FAIL rand_latency%0d: got seen=%b lat=%0d want %0d", f, seen, lat, e_lat);
      end
      checks++;
      if ({bus.pix_count, bus.locked, bus.x_center, bus.y_center, bus.box} !==
          {CntW'(e_pix), e_locked, 11'(e_x), 11'(e_y), e_box}) begin
        errors++;
        $display("FAIL rand_result%0d: got pix=%0d lk=%b x=%0d y=%0d box=%h want %0d %b %0d %0d %h",
                 f, bus.pix_count, bus.locked, bus.x_center, bus.y_center, bus.box,
                 e_pix, e_locked, e_x, e_y, e_box);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int lat, v0; bit seen;
    for (int i = 0; i < 100; i++) drive_px(4000, 0, 0, 1'b1, 300 + i, 200);
    bus.dval = 1'b0; bus.vga_vs = 1'b0;
    tick();
    bus.vga_vs = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.mask, bus.x_center, bus.y_center, bus.pix_count, bus.locked, bus.valid,
         bus.box} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got x=%0d y=%0d pix=%0d lk=%b want all 0",
               bus.x_center, bus.y_center, bus.pix_count, bus.locked);
    end
    tick();
    rst_n = 1'b1;
    model_reset();
    v0 = vcount;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if (vcount !== v0) begin
      errors++;
      $display("FAIL abort_valid: got %0d pulses want 0", vcount - v0);
    end
    // Exactly the minimum count must lock.
    for (int i = 0; i < 64; i++)
      drive_px(4095, $urandom_range(3000), $urandom_range(3000), 1'b1,
               $urandom_range(2047), $urandom_range(2047));
    close_frame(lat, seen);
    model_close();
    checks++;
    if (!seen || lat != CntW + 13 || bus.pix_count !== 64 || bus.locked !== 1'b1 ||
        bus.x_center !== 11'(e_x) || bus.y_center !== 11'(e_y) || bus.box !== e_box) begin
      errors++;
      $display("FAIL min_lock: got lat=%0d pix=%0d lk=%b x=%0d y=%0d want %0d 64 1 %0d %0d",
               lat, bus.pix_count, bus.locked, bus.x_center, bus.y_center, CntW + 13, e_x, e_y);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.red = '0; bus.green = '0; bus.blue = '0; bus.dval = 1'b0;
    bus.x = '0; bus.y = '0; bus.vga_vs = 1'b1;
    model_reset();
    e_lat = 0;
    last_red = 1'b0;
    test_reset();
    test_block();
    test_threshold();
    test_below_min();
    test_vs_during_div();
    test_random();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
